// File: rtl/slow_clock_monitor.sv
// Purpose: measures half-periods of a slow asynchronous square wave, judges lock and flags loss of signal.
// Latency: edge seen 2 clk after sampling; half_period/period_valid/in_range register 1 clk after edge detect.
// Backpressure: none; free-running monitor, period_valid is a one-cycle pulse that is never stalled.
module slow_clock_monitor #(
    parameter int EXPECTED_HALF = 13_500_000,
    parameter int TOLERANCE     = 1_350,
    parameter int TIMEOUT       = 27_000_000,
    parameter int LOCK_COUNT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sig_in,
    input  logic        clr_err,
    output logic        level_out,
    output logic [26:0] half_period,
    output logic        period_valid,
    output logic        in_range,
    output logic        locked,
    output logic        timeout_err,
    output logic [15:0] edge_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_TRACK = 2'd2
    } state_t;

    localparam logic [26:0] C_TIMEOUT = 27'(TIMEOUT);
    localparam logic [26:0] C_CNT_SAT = '1;
    localparam logic [27:0] C_EXP     = 28'(EXPECTED_HALF);
    localparam logic [27:0] C_TOL     = 28'(TOLERANCE);
    localparam logic [3:0]  C_LOCK    = 4'(LOCK_COUNT);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [26:0] r_cnt;
    state_t      r_state;
    state_t      w_next_state;
    logic        w_measure;
    logic        w_edge;
    logic        w_timeout;
    logic [27:0] w_cnt_ext;
    logic [27:0] w_diff;
    logic        w_in_range;
    logic [3:0]  r_good;
    logic [26:0] r_half;
    logic        r_valid;
    logic        r_in_range;
    logic        r_terr;
    logic [15:0] r_edge_cnt;

    // Edges of either polarity look identical; timeout only matters once armed.
    assign w_edge    = r_sync2 ^ r_prev;
    assign w_timeout = (r_state != S_IDLE) && (r_cnt == C_TIMEOUT);

    // Deviation from nominal in 28 bits so the subtraction can never wrap.
    assign w_cnt_ext  = {1'b0, r_cnt};
    assign w_diff     = (w_cnt_ext >= C_EXP) ? (w_cnt_ext - C_EXP) : (C_EXP - w_cnt_ext);
    assign w_in_range = (w_diff <= C_TOL);

    // Two-flop synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Cycle counter: restarts at 1 on each edge so its value at the next edge is the half-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_edge) begin
            r_cnt <= 27'd1;
        end else if (r_cnt != C_CNT_SAT) begin
            r_cnt <= r_cnt + 27'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state; timeout beats a coincident edge so that edge is never measured.
    always_comb begin
        w_next_state = r_state;
        w_measure    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_next_state = S_ARMED;
                end
            end
            S_ARMED, S_TRACK: begin
                if (w_timeout) begin
                    w_next_state = S_IDLE;
                end else if (w_edge) begin
                    w_next_state = S_TRACK;
                    w_measure    = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Measurement registers; half_period and in_range hold across timeouts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_half     <= '0;
            r_in_range <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= w_measure;
            if (w_measure) begin
                r_half     <= r_cnt;
                r_in_range <= w_in_range;
            end
        end
    end

    // Consecutive in-range count, saturating at the lock threshold.
    always_ff @(posedge clk) begin
        if (rst || w_timeout) begin
            r_good <= '0;
        end else if (w_measure) begin
            if (!w_in_range) begin
                r_good <= '0;
            end else if (r_good != C_LOCK) begin
                r_good <= r_good + 4'd1;
            end
        end
    end

    // Sticky loss-of-signal flag; a timeout wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_terr <= 1'b0;
        end else if (w_timeout) begin
            r_terr <= 1'b1;
        end else if (clr_err) begin
            r_terr <= 1'b0;
        end
    end

    // Free-running edge counter in every state, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge_cnt <= '0;
        end else if (w_edge) begin
            r_edge_cnt <= r_edge_cnt + 16'd1;
        end
    end

    assign level_out    = r_sync2;
    assign half_period  = r_half;
    assign period_valid = r_valid;
    assign in_range     = r_in_range;
    assign locked       = (r_state == S_TRACK) && (r_good == C_LOCK);
    assign timeout_err  = r_terr;
    assign edge_cnt     = r_edge_cnt;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Purpose: scoreboard bench for slow_clock_monitor with directed and random half-period sequences.
// Latency: expected measurements queued at each toggle, popped when period_valid appears.
// Backpressure: none; the monitor consumes every pulse the DUT produces.
module tb_slow_clock_monitor;

    localparam int EXP_H = 10;
    localparam int TOL   = 1;
    localparam int TO    = 40;
    localparam int LOCKN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sig_in = 1'b0;
    logic        clr_err = 1'b0;
    logic        level_out;
    logic [26:0] half_period;
    logic        period_valid;
    logic        in_range;
    logic        locked;
    logic        timeout_err;
    logic [15:0] edge_cnt;

    slow_clock_monitor #(
        .EXPECTED_HALF(EXP_H),
        .TOLERANCE    (TOL),
        .TIMEOUT      (TO),
        .LOCK_COUNT   (LOCKN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .clr_err     (clr_err),
        .level_out   (level_out),
        .half_period (half_period),
        .period_valid(period_valid),
        .in_range    (in_range),
        .locked      (locked),
        .timeout_err (timeout_err),
        .edge_cnt    (edge_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int half;
        bit inr;
        bit lck;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: tracks toggles and gaps between them in whole clk cycles.
    int          m_since  = 0;   // cycles since the last toggle
    int          m_phase  = 0;   // 0 waiting for first edge, 1 one edge seen, 2 measuring
    int          m_good   = 0;   // consecutive in-range measurements, capped at LOCKN
    bit          m_terr   = 1'b0;
    bit          m_just_to = 1'b0;
    logic [15:0] m_edges  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_locked();
        return (m_phase == 2) && (m_good == LOCKN);
    endfunction

    // Advance n cycles with sig_in steady; a tracked signal silent for TO cycles is lost.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            m_since++;
            if (m_phase != 0 && m_since == TO) begin
                m_phase   = 0;
                m_good    = 0;
                m_terr    = 1'b1;
                m_just_to = 1'b1;
            end
        end
    endtask

    // One edge of the monitored signal as the model sees it.
    task automatic model_edge();
        int  dev;
        bit  inr;
        exp_t e;
        m_edges = m_edges + 16'd1;
        if (m_phase != 0) begin
            dev = (m_since >= EXP_H) ? m_since - EXP_H : EXP_H - m_since;
            inr = (dev <= TOL);
            m_good  = inr ? ((m_good < LOCKN) ? m_good + 1 : m_good) : 0;
            m_phase = 2;
            e.half = m_since;
            e.inr  = inr;
            e.lck  = (m_good == LOCKN);
            sb.push_back(e);
        end else if (!(m_just_to && m_since == TO)) begin
            m_phase = 1;
        end
        m_just_to = 1'b0;
        m_since   = 0;
    endtask

    // Wait g cycles, then toggle: the DUT should measure a half-period of g.
    task automatic tog(input int g);
        idle(g);
        sig_in = ~sig_in;
        model_edge();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level_out"},    32'(level_out),    0);
        chk({tag, "_half_period"},  32'(half_period),  0);
        chk({tag, "_period_valid"}, 32'(period_valid), 0);
        chk({tag, "_in_range"},     32'(in_range),     0);
        chk({tag, "_locked"},       32'(locked),       0);
        chk({tag, "_timeout_err"},  32'(timeout_err),  0);
        chk({tag, "_edge_cnt"},     32'(edge_cnt),     0);
    endtask

    task automatic model_reset();
        m_since   = 0;
        m_phase   = 0;
        m_good    = 0;
        m_terr    = 1'b0;
        m_just_to = 1'b0;
        m_edges   = '0;
    endtask

    // Monitor: every period_valid pulse must match the oldest expected measurement.
    always @(negedge clk) begin
        if (period_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: half_period=%0d, no measurement expected (t=%0t)",
                         half_period, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("half_period", 32'(half_period), 32'(mon_e.half));
                chk("in_range",    32'(in_range),    32'(mon_e.inr));
                chk("locked_at_valid", 32'(locked),  32'(mon_e.lck));
            end
        end
    end

    initial begin
        int r;
        int g;

        // Reset state.
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        model_reset();

        // Nominal toggling: first edge arms, lock after the fourth measurement.
        tog(10);
        for (int i = 0; i < 5; i++) tog(10);
        idle(5);
        chk("locked_nominal", 32'(locked), 32'(model_locked()));
        chk("edge_cnt_nominal", 32'(edge_cnt), 32'(m_edges));

        // One long half-period breaks lock; four good ones restore it.
        tog(13);
        for (int i = 0; i < 4; i++) tog(10);
        idle(5);
        chk("locked_relock", 32'(locked), 32'(model_locked()));

        // Tolerance boundaries.
        tog(9);
        tog(11);
        tog(8);
        tog(12);
        for (int i = 0; i < 4; i++) tog(10);
        idle(5);
        chk("locked_before_loss", 32'(locked), 32'(model_locked()));

        // Loss of signal while locked.
        idle(50);
        chk("timeout_err_set", 32'(timeout_err), 32'(m_terr));
        chk("locked_after_timeout", 32'(locked), 0);
        chk("edge_cnt_after_timeout", 32'(edge_cnt), 32'(m_edges));

        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        m_terr  = 1'b0;
        chk("timeout_err_cleared", 32'(timeout_err), 32'(m_terr));

        // Clear coinciding with a timeout: the timeout wins.
        tog(10);
        tog(10);
        idle(42);
        chk("timeout_err_before_coincide", 32'(timeout_err), 0);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        chk("timeout_err_clr_vs_timeout", 32'(timeout_err), 1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        m_terr  = 1'b0;
        chk("timeout_err_cleared_again", 32'(timeout_err), 32'(m_terr));

        // Reset mid half-period discards the partial count.
        tog(10);
        tog(10);
        tog(10);
        idle(5);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk_all_zero("midreset");
        model_reset();
        if (sig_in) model_edge();
        for (int i = 0; i < 5; i++) tog(10);
        idle(5);
        chk("edge_cnt_post_reset", 32'(edge_cnt), 32'(m_edges));

        // Randomized half-periods, including near-miss and lost-signal gaps.
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(99, 0);
            if (r < 70)      g = $urandom_range(12, 8);
            else if (r < 88) g = $urandom_range(20, 2);
            else             g = $urandom_range(45, 38);
            tog(g);
        end
        idle(60);
        chk("timeout_err_random", 32'(timeout_err), 32'(m_terr));
        chk("locked_random_end", 32'(locked), 0);
        chk("edge_cnt_random", 32'(edge_cnt), 32'(m_edges));
        chk("pending_measurements", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/slow_clock_monitor.md
SLOW_CLOCK_MONITOR -- requirements
Module: slow_clock_monitor

Interface
REQ-001 SHALL have parameter EXPECTED_HALF, default 13_500_000: nominal half-period of the monitored signal, in clk cycles.
REQ-002 SHALL have parameter TOLERANCE, default 1_350: allowed absolute deviation from EXPECTED_HALF, in clk cycles.
REQ-003 SHALL have parameter TIMEOUT, default 27_000_000: cycles without an edge before loss is declared; TIMEOUT > EXPECTED_HALF + TOLERANCE and < 2^27.
REQ-004 SHALL have parameter LOCK_COUNT, default 4: consecutive in-range half-periods required for lock; range 1..15.
REQ-005 clk  input  1  system clock (27 MHz board clock); sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 sig_in  input  1  asynchronous slow square wave under test.
REQ-008 clr_err  input  1  clears timeout_err when high.
REQ-009 level_out  output  1  synchronized copy of sig_in.
REQ-010 half_period  output  27  last measured half-period, in clk cycles.
REQ-011 period_valid  output  1  one-cycle pulse when half_period updates.
REQ-012 in_range  output  1  last measurement within tolerance.
REQ-013 locked  output  1  signal judged present and on frequency.
REQ-014 timeout_err  output  1  sticky loss-of-signal flag.
REQ-015 edge_cnt  output  16  count of synchronized edges, both polarities; wraps.

Function
REQ-016 sig_in SHALL pass through a 2-flop synchronizer; level_out = second flop; a third flop (prev) holds the previous level_out.
REQ-017 An edge SHALL be detected in any cycle where level_out != prev; rising and falling edges are treated identically.
REQ-018 A 27-bit counter SHALL increment every cycle; on an edge it reloads to 1; it saturates at 2^27-1.
REQ-019 For sig_in toggling exactly every T clk cycles, each measured half_period SHALL equal T.
REQ-020 FSM states SHALL be IDLE, ARMED, and TRACK.
  - IDLE (reset state): first edge -> ARMED; no measurement is made.
  - ARMED: next edge -> TRACK and the first measurement is made.
  - TRACK: every edge is measured.
  - ARMED or TRACK: counter reaching TIMEOUT -> IDLE.
REQ-021 On a measured edge, half_period SHALL load the counter value and period_valid SHALL pulse high for exactly one cycle.
REQ-022 The period_valid pulse SHALL occur in the cycle after the edge-detect cycle, i.e. 3 clk cycles after the first clk edge that samples the new sig_in level.
REQ-023 in_range SHALL be computed as |half_period - EXPECTED_HALF| <= TOLERANCE, in 28-bit unsigned arithmetic without overflow, and SHALL update together with half_period.
REQ-024 A consecutive-good counter (4 bits) SHALL increment, saturating at LOCK_COUNT, on each in-range measurement and clear on any out-of-range measurement.
REQ-025 locked SHALL be 1 while the consecutive-good counter equals LOCK_COUNT and the FSM is in TRACK, and 0 otherwise.
REQ-026 On timeout the following SHALL occur in the same cycle:
  - timeout_err set;
  - locked cleared;
  - consecutive-good counter cleared;
  - FSM to IDLE.
  half_period and in_range SHALL hold their last values.
REQ-027 timeout_err SHALL stay set until clr_err or rst; if clr_err and a timeout occur in the same cycle, timeout_err SHALL be set.
REQ-028 edge_cnt SHALL increment on every detected edge in all states and wrap from 0xFFFF to 0.
REQ-029 An edge in the same cycle the counter reaches TIMEOUT SHALL be treated as a timeout, not as a measurement.

Reset
REQ-030 Synchronous rst SHALL drive the following, taking precedence over all other inputs including a simultaneous edge or clr_err:
  - FSM = IDLE;
  - counter = 0;
  - synchronizer and prev flops = 0;
  - level_out = 0, half_period = 0, period_valid = 0, in_range = 0, locked = 0, timeout_err = 0, edge_cnt = 0.
REQ-031 rst asserted mid-measurement SHALL discard the partial count; after release the first edge SHALL yield no period_valid.

Verification (EXPECTED_HALF=10, TOLERANCE=1, TIMEOUT=40, LOCK_COUNT=4)
REQ-032 sig_in toggling every 10 clk cycles after reset:
  - no period_valid on the first edge;
  - every subsequent period_valid shows half_period=10, in_range=1;
  - locked=1 after the 4th measurement.
REQ-033 Locked, then one half-period of 13:
  - half_period=13, in_range=0, locked=0;
  - locked returns after 4 further half-periods of 10.
REQ-034 Boundary check:
  - half-periods of 9 and 11 -> in_range=1;
  - half-periods of 8 and 12 -> in_range=0.
REQ-035 sig_in held constant for 40+ cycles while locked:
  - timeout_err=1, locked=0, FSM in IDLE;
  - clr_err pulse -> timeout_err=0;
  - clr_err in the same cycle as a timeout -> timeout_err=1.
REQ-036 rst pulse mid half-period:
  - all outputs 0 in the next cycle;
  - edge_cnt=0;
  - no period_valid until the second post-reset edge.
